// File: rtl/save_target_pkg.sv
// Shared constants, FSM encoding and sprite contents for the save point target.
package save_target_pkg;

    localparam int SCREEN_W = 800;
    localparam int SCREEN_H = 600;

    // Bullet box size, identical to the bullet block's own sprite box
    localparam int BULLET_W = 4;
    localparam int BULLET_H = 4;

    // Sprite ROM word that marks a see-through texel
    localparam logic [11:0] RGB_TRANSPARENT = 12'hFFF;

    // Sprite is 16x16, so the texel address is {row[3:0], col[3:0]}
    localparam int SPRITE_AW = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLASH = 2'd1,
        COOL  = 2'd2
    } state_t;

    // Sprite art: a framed gradient whose last row and last column are see-through
    function automatic logic [11:0] spriteTexel(input logic [SPRITE_AW-1:0] addr);
        logic [11:0] word;
        if (addr[7:4] == 4'hF || addr[3:0] == 4'hF) begin
            word = RGB_TRANSPARENT;
        end else begin
            word = {addr[7:4], addr[3:0], 4'hA};
        end
        return word;
    endfunction

endpackage

// File: rtl/save_target_if.sv
// Signal bundle between the game core / VGA mixer and the save point target.
interface save_target_if;

    logic        update_tick;
    logic [9:0]  col;
    logic [9:0]  row;
    logic [9:0]  bullet_x;
    logic [9:0]  bullet_y;
    logic [9:0]  kid_x;
    logic [9:0]  kid_y;
    logic        bullet_hit;
    logic        save_valid;
    logic [9:0]  save_x;
    logic [9:0]  save_y;
    logic        is_target;
    logic [11:0] target_rgb;

    // Game side: supplies positions, scan position and the update strobe
    modport master (
        output update_tick, col, row, bullet_x, bullet_y, kid_x, kid_y,
        input  bullet_hit, save_valid, save_x, save_y, is_target, target_rgb
    );

    // Target side: consumes positions, reports hits, respawn point and pixels
    modport slave (
        input  update_tick, col, row, bullet_x, bullet_y, kid_x, kid_y,
        output bullet_hit, save_valid, save_x, save_y, is_target, target_rgb
    );

endinterface

// File: rtl/save_target_rom.sv
// Sprite ROM for the save point; one clock of read latency, which is the
// whole pixel-path delay seen by the VGA mixer.
module save_target_rom
    import save_target_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [SPRITE_AW-1:0] addr_i,
    output logic [11:0]          data_o
);

    logic [11:0] data_q;

    // Registered texel read
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q <= '0;
        end else begin
            data_q <= spriteTexel(addr_i);
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/save_target.sv
// Shootable save point: tests the bullet against its box on each update tick,
// retires the bullet on a hit, latches the kid as respawn point, then flashes
// and cools down. Also renders its own sprite pixel one clock after the scan.
module save_target
    import save_target_pkg::*;
#(
    parameter int TARGET_X    = 400,
    parameter int TARGET_Y    = 300,
    parameter int TARGET_W    = 16,
    parameter int TARGET_H    = 16,
    parameter int FLASH_TICKS = 30,
    parameter int COOL_TICKS  = 60
) (
    input  logic         clk,
    input  logic         rst,
    save_target_if.slave bus
);

    localparam logic [5:0] FLASH_LAST = 6'(FLASH_TICKS - 1);
    localparam logic [5:0] COOL_LAST  = 6'(COOL_TICKS - 1);

    state_t      state_q;
    logic [5:0]  tickCnt_q;
    logic        bulletHit_q;
    logic        saveValid_q;
    logic [9:0]  saveX_q;
    logic [9:0]  saveY_q;
    logic        inBox_q;

    logic [10:0] bx;
    logic [10:0] by;
    logic        parked;
    logic        overlap;
    logic        inBox_d;
    logic [9:0]  rowOff;
    logic [9:0]  colOff;
    logic [SPRITE_AW-1:0] pixAddr_d;
    logic [11:0] romWord;
    logic        isTarget;
    logic [11:0] rgb;

    // Bullet coordinates are stored plus one; sums use 12 bits so they never wrap
    assign bx      = {1'b0, bus.bullet_x} - 11'd1;
    assign by      = {1'b0, bus.bullet_y} - 11'd1;
    assign parked  = (bx >= 11'(SCREEN_W));
    assign overlap = !parked
                   && ({1'b0, bx} < 12'(TARGET_X + TARGET_W))
                   && ({1'b0, bx} + 12'(BULLET_W) > 12'(TARGET_X))
                   && ({1'b0, by} < 12'(TARGET_Y + TARGET_H))
                   && ({1'b0, by} + 12'(BULLET_H) > 12'(TARGET_Y));

    // Hit detection, respawn latch and the IDLE/FLASH/COOL sequencer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            tickCnt_q   <= '0;
            bulletHit_q <= 1'b0;
            saveValid_q <= 1'b0;
            saveX_q     <= '0;
            saveY_q     <= '0;
        end else begin
            bulletHit_q <= bus.update_tick && overlap;
            if (bus.update_tick) begin
                case (state_q)
                    IDLE: begin
                        if (overlap) begin
                            saveX_q     <= bus.kid_x;
                            saveY_q     <= bus.kid_y;
                            saveValid_q <= 1'b1;
                            tickCnt_q   <= '0;
                            state_q     <= FLASH;
                        end
                    end
                    FLASH: begin
                        if (tickCnt_q == FLASH_LAST) begin
                            tickCnt_q <= '0;
                            state_q   <= COOL;
                        end else begin
                            tickCnt_q <= tickCnt_q + 6'd1;
                        end
                    end
                    COOL: begin
                        if (tickCnt_q == COOL_LAST) begin
                            tickCnt_q <= '0;
                            state_q   <= IDLE;
                        end else begin
                            tickCnt_q <= tickCnt_q + 6'd1;
                        end
                    end
                    default: begin
                        tickCnt_q <= '0;
                        state_q   <= IDLE;
                    end
                endcase
            end
        end
    end

    // Scan position inside the sprite box and its texel address
    assign rowOff  = bus.row - 10'(TARGET_Y);
    assign colOff  = bus.col - 10'(TARGET_X);
    assign inBox_d = (bus.col >= 10'(TARGET_X)) && (bus.col < 10'(TARGET_X + TARGET_W))
                  && (bus.row >= 10'(TARGET_Y)) && (bus.row < 10'(TARGET_Y + TARGET_H));
    assign pixAddr_d = inBox_d ? SPRITE_AW'(rowOff * 10'(TARGET_W) + colOff) : '0;

    save_target_rom u_rom (
        .clk    (clk),
        .rst    (rst),
        .addr_i (pixAddr_d),
        .data_o (romWord)
    );

    // Delay the in-box flag to line up with the ROM read
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inBox_q <= 1'b0;
        end else begin
            inBox_q <= inBox_d;
        end
    end

    // Pixel colour: inverted on alternate 4-tick phases of FLASH, transparent texels untouched
    always_comb begin
        isTarget = 1'b0;
        rgb      = 12'h000;
        if (inBox_q) begin
            rgb = romWord;
            if (romWord != RGB_TRANSPARENT) begin
                isTarget = 1'b1;
                if (state_q == FLASH && tickCnt_q[2]) begin
                    rgb = romWord ^ 12'hFFF;
                end
            end
        end
    end

    assign bus.bullet_hit = bulletHit_q;
    assign bus.save_valid = saveValid_q;
    assign bus.save_x     = saveX_q;
    assign bus.save_y     = saveY_q;
    assign bus.is_target  = isTarget;
    assign bus.target_rgb = rgb;

endmodule

// File: tb/tb_save_target.sv
// Directed bench for the save point target: reset, hit box edges, FSM timing,
// respawn latching and the sprite pixel path.
module tb_save_target;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    save_target_if bus ();

    save_target dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // 100 MHz free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One clock with the given bullet/kid positions and tick level
    task automatic applyStimulus(input logic [9:0] bxIn, input logic [9:0] byIn,
                                 input logic [9:0] kxIn, input logic [9:0] kyIn,
                                 input logic tick);
        bus.bullet_x    = bxIn;
        bus.bullet_y    = byIn;
        bus.kid_x       = kxIn;
        bus.kid_y       = kyIn;
        bus.update_tick = tick;
        @(posedge clk);
        #1;
        bus.update_tick = 1'b0;
    endtask

    // One clock of scan at (c, r) with no tick
    task automatic scanPixel(input logic [9:0] c, input logic [9:0] r);
        bus.col         = c;
        bus.row         = r;
        bus.bullet_x    = 10'd0;
        bus.update_tick = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks          = 0;
        failures        = 0;
        rst             = 1'b1;
        bus.update_tick = 1'b0;
        bus.col         = 10'd0;
        bus.row         = 10'd0;
        bus.bullet_x    = 10'd0;
        bus.bullet_y    = 10'd0;
        bus.kid_x       = 10'd0;
        bus.kid_y       = 10'd0;

        // Asynchronous reset before any clock edge
        #2 rst = 1'b0;
        #1;
        checkOutput("rst_hit",   32'(bus.bullet_hit), 32'd0);
        checkOutput("rst_valid", 32'(bus.save_valid), 32'd0);
        checkOutput("rst_sx",    32'(bus.save_x),     32'd0);
        checkOutput("rst_sy",    32'(bus.save_y),     32'd0);
        checkOutput("rst_ist",   32'(bus.is_target),  32'd0);
        checkOutput("rst_rgb",   32'(bus.target_rgb), 32'h000);
        checkOutput("rst_state", 32'(dut.state_q),    32'd0);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;

        // bx=396: right edge reaches 400, not past it -> no hit
        applyStimulus(10'd397, 10'd301, 10'd100, 10'd500, 1'b1);
        checkOutput("edge_left_nohit", 32'(bus.bullet_hit), 32'd0);
        checkOutput("edge_left_state", 32'(dut.state_q),    32'd0);

        // Overlapping bullet without a tick never hits
        for (int i = 0; i < 3; i++) begin
            applyStimulus(10'd401, 10'd301, 10'd100, 10'd500, 1'b0);
            checkOutput("notick_nohit", 32'(bus.bullet_hit), 32'd0);
        end

        // Parked bullet over the target rows
        for (int i = 0; i < 3; i++) begin
            applyStimulus(10'd801, 10'd301, 10'd100, 10'd500, 1'b1);
            checkOutput("parked_nohit", 32'(bus.bullet_hit), 32'd0);
        end
        checkOutput("parked_valid", 32'(bus.save_valid), 32'd0);

        // IDLE hit: bx=400 -> latch kid (100,500), enter FLASH
        applyStimulus(10'd401, 10'd301, 10'd100, 10'd500, 1'b1);
        checkOutput("hit1_pulse", 32'(bus.bullet_hit), 32'd1);
        checkOutput("hit1_valid", 32'(bus.save_valid), 32'd1);
        checkOutput("hit1_sx",    32'(bus.save_x),     32'd100);
        checkOutput("hit1_sy",    32'(bus.save_y),     32'd500);
        checkOutput("hit1_state", 32'(dut.state_q),    32'd1);
        applyStimulus(10'd0, 10'd301, 10'd100, 10'd500, 1'b0);
        checkOutput("hit1_pulse_end", 32'(bus.bullet_hit), 32'd0);

        // FLASH cnt 0->1: bx=392 too far left
        applyStimulus(10'd393, 10'd301, 10'd200, 10'd200, 1'b1);
        checkOutput("left_nohit", 32'(bus.bullet_hit), 32'd0);
        // cnt 1->2: bx=416 equals right edge
        applyStimulus(10'd417, 10'd301, 10'd200, 10'd200, 1'b1);
        checkOutput("right_nohit", 32'(bus.bullet_hit), 32'd0);
        // cnt 2->3: bx=397, by=315 corner overlap -> hit, no re-save
        applyStimulus(10'd398, 10'd316, 10'd200, 10'd200, 1'b1);
        checkOutput("flash_hit",   32'(bus.bullet_hit), 32'd1);
        checkOutput("flash_sx",    32'(bus.save_x),     32'd100);
        checkOutput("flash_sy",    32'(bus.save_y),     32'd500);
        checkOutput("flash_state", 32'(dut.state_q),    32'd1);

        // Pixel at cnt=3 (not inverted)
        scanPixel(10'd400, 10'd300);
        checkOutput("flash_pulse_end", 32'(bus.bullet_hit), 32'd0);
        checkOutput("pix_flash_ist",   32'(bus.is_target),  32'd1);
        checkOutput("pix_flash_rgb",   32'(bus.target_rgb), 32'h00A);
        // cnt 3->4: inverted phase
        applyStimulus(10'd0, 10'd0, 10'd200, 10'd200, 1'b1);
        scanPixel(10'd400, 10'd300);
        checkOutput("pix_inv_ist", 32'(bus.is_target),  32'd1);
        checkOutput("pix_inv_rgb", 32'(bus.target_rgb), 32'hFF5);
        scanPixel(10'd415, 10'd300);
        checkOutput("pix_inv_transp", 32'(bus.is_target), 32'd0);

        // cnt 4->29 stays in FLASH, tick at 29 moves to COOL
        for (int i = 0; i < 25; i++) applyStimulus(10'd0, 10'd0, 10'd0, 10'd0, 1'b1);
        checkOutput("flash_last_state", 32'(dut.state_q), 32'd1);
        applyStimulus(10'd0, 10'd0, 10'd0, 10'd0, 1'b1);
        checkOutput("cool_state", 32'(dut.state_q), 32'd2);

        // COOL hit (cnt 0->1): pulse but no re-save
        applyStimulus(10'd401, 10'd301, 10'd300, 10'd400, 1'b1);
        checkOutput("cool_hit", 32'(bus.bullet_hit), 32'd1);
        checkOutput("cool_sx",  32'(bus.save_x),     32'd100);
        checkOutput("cool_sy",  32'(bus.save_y),     32'd500);

        // Pixel path in COOL
        scanPixel(10'd400, 10'd300);
        checkOutput("pix_cool_ist", 32'(bus.is_target),  32'd1);
        checkOutput("pix_cool_rgb", 32'(bus.target_rgb), 32'h00A);
        scanPixel(10'd405, 10'd302);
        checkOutput("pix_mid_rgb", 32'(bus.target_rgb), 32'h25A);
        scanPixel(10'd415, 10'd300);
        checkOutput("pix_transp_ist", 32'(bus.is_target), 32'd0);
        scanPixel(10'd416, 10'd300);
        checkOutput("pix_out_ist", 32'(bus.is_target),  32'd0);
        checkOutput("pix_out_rgb", 32'(bus.target_rgb), 32'h000);

        // cnt 1->59 stays in COOL, tick at 59 returns to IDLE
        for (int i = 0; i < 58; i++) applyStimulus(10'd0, 10'd0, 10'd0, 10'd0, 1'b1);
        checkOutput("cool_last_state", 32'(dut.state_q), 32'd2);
        applyStimulus(10'd0, 10'd0, 10'd0, 10'd0, 1'b1);
        checkOutput("idle_again_state", 32'(dut.state_q), 32'd0);

        // New IDLE hit updates the respawn point
        applyStimulus(10'd401, 10'd301, 10'd123, 10'd456, 1'b1);
        checkOutput("hit2_pulse", 32'(bus.bullet_hit), 32'd1);
        checkOutput("hit2_sx",    32'(bus.save_x),     32'd123);
        checkOutput("hit2_sy",    32'(bus.save_y),     32'd456);
        checkOutput("hit2_state", 32'(dut.state_q),    32'd1);

        // Reset mid-FLASH with a tick and overlapping bullet held during reset
        bus.update_tick = 1'b1;
        bus.bullet_x    = 10'd401;
        rst             = 1'b0;
        #1;
        checkOutput("midrst_state", 32'(dut.state_q),    32'd0);
        checkOutput("midrst_valid", 32'(bus.save_valid), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("midrst_hit", 32'(bus.bullet_hit), 32'd0);
        checkOutput("midrst_sx",  32'(bus.save_x),     32'd0);
        bus.update_tick = 1'b0;
        rst             = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("postrst_state", 32'(dut.state_q),    32'd0);
        checkOutput("postrst_hit",   32'(bus.bullet_hit), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
